// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM-stage requester (master) and data_mem_responder (slave).
// rsp_err exists only when MEM_BOUNDS_CHECK_EN is defined.
interface data_mem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
`ifdef MEM_BOUNDS_CHECK_EN
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Stalling data memory for the MEM stage: one request at a time, WAIT_CYCLES wait states, held response.
// Optional MEM_BOUNDS_CHECK_EN: addresses >= DEPTH fault (rsp_err) instead of aliasing modulo DEPTH.
module data_mem_responder #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_en_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic              req_ready;
    logic              accept;
    logic              complete;
    logic              mem_wr;

    assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    assign oor         = {1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH);
    assign bus.rsp_err = rsp_err_q;
`else
    assign oor = 1'b0;
    logic unused_err;
    assign unused_err = rsp_err_q ^ (^addr_q);
`endif

    // ready_en_q keeps req_ready low until the first edge after reset release
    assign req_ready = ready_en_q & ((state_q == S_IDLE) | ((state_q == S_RESP) & bus.rsp_ready));
    assign accept    = bus.req_valid & req_ready;
    assign complete  = rsp_valid_q & bus.rsp_ready;
    assign mem_wr    = rst & (state_q == S_ACCESS) & we_q & ~oor;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                rsp_we_d    = we_q;
                rsp_err_d   = oor;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
                if (oor)       rsp_rdata_d = '0;
                else if (we_q) rsp_rdata_d = wdata_q;
                else           rsp_rdata_d = mem[idx];
            end
            S_RESP: begin
                if (complete) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
        // accept only happens in IDLE or in RESP alongside completion, so it overrides the above
        if (accept) begin
            we_d    = bus.req_we;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
                state_d = S_ACCESS;
            end else begin
                state_d = S_WAIT;
                cnt_d   = WAIT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_en_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_en_q  <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_wr) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus randomized traffic vs. an array model.
module tb_data_mem_responder;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1024;
    localparam int WAITC  = 2;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] model [DEPTH];
    bit                kn [DEPTH];
    int                known_q[$];
    exp_t              exp_q[$];

    data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a ();
    data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b ();

    data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC))
        u_dut_a (.clk(clk), .rst(rst), .bus(a));
    data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(0))
        u_dut_b (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: a plain word array indexed by addr mod DEPTH, faulting above DEPTH when bounds-checked.
    task automatic model_access(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wd, output exp_t e);
        int idx;
        bit oor;
        idx = int'(addr) % DEPTH;
        oor = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        oor = (int'(addr) >= DEPTH);
`endif
        e.we  = we;
        e.err = oor;
        if (oor) begin
            e.rdata = '0;
        end else if (we) begin
            e.rdata    = wd;
            model[idx] = wd;
            if (!kn[idx]) begin
                kn[idx] = 1'b1;
                known_q.push_back(idx);
            end
        end else begin
            e.rdata = model[idx];
        end
    endtask

    task automatic send_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a.req_valid = 1'b1;
        a.req_we    = we;
        a.req_addr  = addr;
        a.req_wdata = wd;
        while (a.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 100), 32'd1);
        model_access(we, addr, wd, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.req_valid = 1'b0;
        a.req_we    = 1'($urandom);
        a.req_addr  = ADDR_W'($urandom);
        a.req_wdata = DATA_W'($urandom);
    endtask

    // Called right after the accepting edge; checks latency and response contents.
    task automatic wait_rsp_a(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (a.rsp_valid !== 1'b1 && lat < 50);
        chk({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
        if (exp_q.size() == 0) begin
            chk({tag, "_exp_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_we"}, 32'(a.rsp_we), 32'(e.we));
            chk({tag, "_rdata"}, 32'(a.rsp_rdata), 32'(e.rdata));
`ifdef MEM_BOUNDS_CHECK_EN
            chk({tag, "_err"}, 32'(a.rsp_err), 32'(e.err));
`endif
        end
    endtask

    task automatic finish_rsp_a(input string tag, input int hold);
        logic [DATA_W-1:0] rd;
        logic              rw;
        rd = a.rsp_rdata;
        rw = a.rsp_we;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(a.rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, 32'(a.rsp_rdata), 32'(rd));
            chk({tag, "_hold_we"}, 32'(a.rsp_we), 32'(rw));
            chk({tag, "_hold_ready"}, 32'(a.req_ready), 32'd0);
        end
        @(negedge clk);
        a.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a.rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(a.rsp_valid), 32'd0);
        chk({tag, "_done_rdata_kept"}, 32'(a.rsp_rdata), 32'(rd));
    endtask

    task automatic txn_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input string tag, input int hold);
        send_a(we, addr, wd);
        wait_rsp_a(tag);
        finish_rsp_a(tag, hold);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        exp_t              e;
        int                n;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;

        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b0;
        a.req_valid = 1'b0; a.req_we = 1'b0; a.req_addr = '0; a.req_wdata = '0; a.rsp_ready = 1'b0;
        b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.rsp_ready = 1'b0;

        // reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(a.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(a.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(a.rsp_rdata), 32'd0);
        chk("rst_rsp_we", 32'(a.rsp_we), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("rst_rsp_err", 32'(a.rsp_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req_ready", 32'(a.req_ready), 32'd1);

        // store then load
        txn_a(1'b1, 12'h010, 16'hBEEF, "st_beef", 1);
        txn_a(1'b0, 12'h010, 16'h0000, "ld_beef", 0);

        // backpressure with the next request waiting
        send_a(1'b0, 12'h010, 16'h0000);
        wait_rsp_a("bp_load");
        rd = a.rsp_rdata;
        @(negedge clk);
        a.req_valid = 1'b1; a.req_we = 1'b1; a.req_addr = 12'h011; a.req_wdata = 16'h4242;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(a.rsp_valid), 32'd1);
            chk("bp_rdata", 32'(a.rsp_rdata), 32'(rd));
            chk("bp_req_ready", 32'(a.req_ready), 32'd0);
        end
        @(negedge clk);
        a.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a.req_ready), 32'd1);
        model_access(1'b1, 12'h011, 16'h4242, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.req_valid = 1'b0;
        a.rsp_ready = 1'b0;
        chk("bp_b2b_valid_drop", 32'(a.rsp_valid), 32'd0);
        wait_rsp_a("bp_next");
        finish_rsp_a("bp_next", 0);

        // reset during WAIT drops the store
        txn_a(1'b1, 12'h020, 16'h5555, "st_5555", 0);
        @(negedge clk);
        a.req_valid = 1'b1; a.req_we = 1'b1; a.req_addr = 12'h020; a.req_wdata = 16'hAAAA;
        @(posedge clk);
        #1;
        a.req_valid = 1'b0;
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wait_valid", 32'(a.rsp_valid), 32'd0);
        txn_a(1'b0, 12'h020, 16'h0000, "ld_after_wait_rst", 0);

        // reset across the ACCESS edge drops the store
        @(negedge clk);
        a.req_valid = 1'b1; a.req_we = 1'b1; a.req_addr = 12'h020; a.req_wdata = 16'hCCCC;
        @(posedge clk);
        #1;
        a.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_access_valid", 32'(a.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn_a(1'b0, 12'h020, 16'h0000, "ld_after_acc_rst", 0);

        // asynchronous reset mid-cycle with a response pending
        send_a(1'b0, 12'h010, 16'h0000);
        wait_rsp_a("async_pre");
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(a.rsp_valid), 32'd0);
        chk("async_rdata", 32'(a.rsp_rdata), 32'd0);
        chk("async_ready", 32'(a.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("async_rel_ready", 32'(a.req_ready), 32'd1);

        // out-of-range store: aliases without the bounds check, faults with it
        txn_a(1'b1, 12'h005, 16'h0101, "st_005", 0);
        txn_a(1'b1, 12'h405, 16'h7777, "st_oor", 0);
        txn_a(1'b0, 12'h005, 16'h0000, "ld_alias", 0);

        // zero-wait instance, back-to-back with rsp_ready tied high
        b.rsp_ready = 1'b1;
        @(negedge clk);
        b.req_valid = 1'b1; b.req_we = 1'b1; b.req_addr = 12'h3FF; b.req_wdata = 16'h1234;
        chk("b_idle_ready", 32'(b.req_ready), 32'd1);
        @(posedge clk);
        #1;
        b.req_we = 1'b0;
        b.req_wdata = DATA_W'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b.req_ready !== 1'b1 && n < 10);
        chk("b_accept_spacing", 32'(n), 32'd2);
        chk("b_st_valid", 32'(b.rsp_valid), 32'd1);
        chk("b_st_we", 32'(b.rsp_we), 32'd1);
        chk("b_st_rdata", 32'(b.rsp_rdata), 32'h1234);
        @(posedge clk);
        #1;
        b.req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b.rsp_valid !== 1'b1 && n < 10);
        chk("b_ld_latency", 32'(n), 32'd2);
        chk("b_ld_we", 32'(b.rsp_we), 32'd0);
        chk("b_ld_rdata", 32'(b.rsp_rdata), 32'h1234);
        @(posedge clk);
        #1;
        chk("b_ld_done", 32'(b.rsp_valid), 32'd0);
        b.rsp_ready = 1'b0;

        // randomized traffic against the array model
        for (int i = 0; i < 40; i++) begin
            we = ($urandom_range(0, 1) == 1) || (known_q.size() == 0);
            if (we) begin
                addr = ADDR_W'($urandom_range(0, 2 * DEPTH - 1));
                wd   = DATA_W'($urandom);
            end else begin
                addr = ADDR_W'(known_q[$urandom_range(0, known_q.size() - 1)]);
                if ($urandom_range(0, 3) == 0) addr = addr + ADDR_W'(DEPTH);
                wd   = DATA_W'($urandom);
            end
            txn_a(we, addr, wd, "rnd", $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name:
data_mem_responder

Overview:
- Memory-side responder for the processor's MEM stage: it answers load/store requests issued by the pipeline.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs the access on an internal word array, then returns a response held until the requester takes it.
- Replaces the zero-latency data memory so the pipeline controller can be exercised against a stalling memory.

Parameters:
- ADDR_W, 12, request address width in words.
- DATA_W, 16, data word width.
- DEPTH, 1024, number of words stored; must be a power of two and ≤ 2^ADDR_W.
- WAIT_CYCLES, 2, wait states between accept and access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response this cycle.
- rsp_we  out  1  echo of req_we for the response.
- rsp_rdata  out  DATA_W  load data; for stores, an echo of the stored data.
- rsp_err  out  1  address fault. Exists only with MEM_BOUNDS_CHECK_EN; otherwise the port is absent.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - req_ready=0 while rst=0, then 1 from the first cycle after release.
  - rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not cleared.
- Reset mid-operation: any latched request is dropped. A store still in IDLE/WAIT is never written; a store in ACCESS at reset is not written.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - On accept, req_we, req_addr and req_wdata are latched; inputs are don't-care afterwards.
  - A response completes on a rising edge with rsp_valid & rsp_ready.
- States:
  - IDLE: req_ready=1. On accept, go to ACCESS if WAIT_CYCLES=0; otherwise go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT: req_ready=0. If cnt=0 go to ACCESS, else cnt decrements. WAIT lasts exactly WAIT_CYCLES cycles.
  - ACCESS: req_ready=0.
    - Store: array[addr mod DEPTH] is written with the latched data on this edge; rsp_rdata takes the latched wdata.
    - Load: rsp_rdata takes array[addr mod DEPTH].
    - rsp_we is loaded on this edge; state goes to RESP.
  - RESP:
    - rsp_valid=1; rsp_rdata, rsp_we and rsp_err are held stable until completion.
    - req_ready = rsp_ready (back-to-back allowed).
    - On completion with a simultaneous accept, go directly to WAIT/ACCESS per the IDLE rule.
    - On completion with no accept, go to IDLE and drop rsp_valid. rsp_rdata keeps its last value.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge. Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
- Ordering: a load following a store to the same address returns the stored value.
- Address wrap: without the bounds check, only the low log2(DEPTH) address bits are used, so addr DEPTH+k aliases k.
- Backpressure: RESP may hold indefinitely; no request is accepted while a response is pending without rsp_ready.
- req_valid in WAIT/ACCESS is ignored (not accepted, not lost by the responder; the requester must hold it).

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- When defined:
  - A request with req_addr ≥ DEPTH follows the normal state sequence and latency.
  - In ACCESS the store is suppressed (array unchanged) and rsp_rdata=0.
  - rsp_err=1 during RESP for that response, and 0 for in-range responses.
- When undefined: rsp_err is not present and out-of-range addresses alias modulo DEPTH as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> req_ready=1 next cycle, rsp_valid=0, rsp_rdata=0. Assert rst=0 asynchronously mid-cycle -> outputs cleared without waiting for clk.
- Store then load (WAIT_CYCLES=2):
  - Store 0xBEEF to addr 0x010 -> rsp_valid high 3 edges after accept, rsp_we=1, rsp_rdata=0xBEEF.
  - Load addr 0x010 -> rsp_rdata=0xBEEF, rsp_we=0.
- Backpressure: with a load response pending, hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata stable and req_ready=0 throughout. Then rsp_ready=1 with req_valid=1 -> next request accepted on the same edge.
- WAIT_CYCLES=0 back-to-back: store 0x1234 @0x3FF, then immediately load @0x3FF with rsp_ready tied 1 -> accepts every 2 cycles, load returns 0x1234.
- Reset mid-store: accept store 0xAAAA @0x020 (old value 0x5555), pulse rst=0 during WAIT -> after recovery, load @0x020 returns 0x5555.
- Out-of-range (DEPTH=1024), store 0x7777 @0x405:
  - With MEM_BOUNDS_CHECK_EN: rsp_err=1, rsp_rdata=0, array unchanged.
  - Without: load @0x005 returns 0x7777.
